// File: rtl/pipeline_stage1.sv
// pipeline_stage1: first stage of a two-stage fetch/issue pipeline.
// Sequences a startup reset window, fetches opcode bytes from memory,
// stalls for stage-2 bus requests and halts on stage-2 break requests.
// Every output except fetch_req and halted comes straight from a flop, so
// stage 2 can safely sample on the falling edge of the same cycle.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RSEQ  | startup window; flag_reset=1, NOP issued, all inputs ignored
//   FETCH | normal fetch; opcode accepted when mem_ready=1
//   STALL | stage 2 owns the bus; NOP issued, no PC increment
//   HALT  | break taken; NOP held until resume (break_in wins over resume)
module pipeline_stage1 #(
  parameter int               WIDTH        = 8,
  parameter int               RESET_CYCLES = 3,
  parameter logic [WIDTH-1:0] NOP          = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_ready,
  input  logic             bus_request_in,
  input  logic             pcra_flip_in,
  input  logic             break_in,
  input  logic             resume,
  output logic [WIDTH-1:0] instruction,
  output logic             flag_reset,
  output logic             flag_pcraflip,
  output logic             fetch_req,
  output logic             pc_inc,
  output logic             halted
);

  typedef enum logic [1:0] {
    RSEQ  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Final count value of the startup window (counter runs 0..RESET_CYCLES-1).
  localparam logic [3:0] LP_CNT_LAST = 4'(RESET_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_instruction;
  logic             r_flag_reset;
  logic             r_flag_pcraflip;
  logic             r_pc_inc;

  // Single FSM: state, startup counter and all registered stage-2 outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= RSEQ;
      r_cnt           <= 4'd0;
      r_instruction   <= NOP;
      r_flag_reset    <= 1'b1;
      r_flag_pcraflip <= 1'b0;
      r_pc_inc        <= 1'b1;
    end else begin
      // PC/RA selection follows stage 2 in every state except the startup window.
      if ((r_state != RSEQ) && pcra_flip_in) begin
        r_flag_pcraflip <= ~r_flag_pcraflip;
      end

      case (r_state)
        RSEQ: begin
          r_instruction <= NOP;
          r_pc_inc      <= 1'b1;
          if (r_cnt == LP_CNT_LAST) begin
            r_state      <= FETCH;
            r_cnt        <= 4'd0;
            r_flag_reset <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + 4'd1;
            r_flag_reset <= 1'b1;
          end
        end

        FETCH: begin
          // break_in > bus_request_in > mem_ready
          if (break_in) begin
            r_state       <= HALT;
            r_instruction <= NOP;
            r_pc_inc      <= 1'b1;
          end else if (bus_request_in) begin
            // Any byte presented this cycle is dropped; it is refetched later
            // because the PC was not advanced.
            r_state       <= STALL;
            r_instruction <= NOP;
            r_pc_inc      <= 1'b1;
          end else if (mem_ready) begin
            r_instruction <= mem_data;
            r_pc_inc      <= 1'b0;
          end else begin
            r_instruction <= NOP;
            r_pc_inc      <= 1'b1;
          end
        end

        STALL: begin
          r_instruction <= NOP;
          r_pc_inc      <= 1'b1;
          if (break_in) begin
            r_state <= HALT;
          end else if (!bus_request_in) begin
            r_state <= FETCH;
          end
        end

        HALT: begin
          r_instruction <= NOP;
          r_pc_inc      <= 1'b1;
          if (resume && !break_in) begin
            r_state <= FETCH;
          end
        end

        default: begin
          r_state       <= RSEQ;
          r_cnt         <= 4'd0;
          r_instruction <= NOP;
          r_flag_reset  <= 1'b1;
          r_pc_inc      <= 1'b1;
        end
      endcase
    end
  end

  assign instruction   = r_instruction;
  assign flag_reset    = r_flag_reset;
  assign flag_pcraflip = r_flag_pcraflip;
  assign pc_inc        = r_pc_inc;
  assign fetch_req     = (r_state == FETCH);
  assign halted        = (r_state == HALT);

endmodule

// File: tb/tb_pipeline_stage1.sv
// Directed bench for pipeline_stage1 with default parameters.
module tb_pipeline_stage1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       bus_request_in;
  logic       pcra_flip_in;
  logic       break_in;
  logic       resume;
  logic [7:0] instruction;
  logic       flag_reset;
  logic       flag_pcraflip;
  logic       fetch_req;
  logic       pc_inc;
  logic       halted;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipeline_stage1 #(.WIDTH(8), .RESET_CYCLES(3), .NOP(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .bus_request_in(bus_request_in),
    .pcra_flip_in  (pcra_flip_in),
    .break_in      (break_in),
    .resume        (resume),
    .instruction   (instruction),
    .flag_reset    (flag_reset),
    .flag_pcraflip (flag_pcraflip),
    .fetch_req     (fetch_req),
    .pc_inc        (pc_inc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_data = 8'h3C; mem_ready = 1'b1; bus_request_in = 1'b0;
    pcra_flip_in = 1'b0; break_in = 1'b0; resume = 1'b0;
    #3;
    vec_cnt++; if (instruction !== 8'h00) begin err_cnt++; $display("FAIL rst_instr got %h want 00", instruction); end
    vec_cnt++; if (flag_reset !== 1'b1) begin err_cnt++; $display("FAIL rst_flag_reset got %b want 1", flag_reset); end
    vec_cnt++; if (flag_pcraflip !== 1'b0) begin err_cnt++; $display("FAIL rst_pcraflip got %b want 0", flag_pcraflip); end
    vec_cnt++; if (pc_inc !== 1'b1) begin err_cnt++; $display("FAIL rst_pc_inc got %b want 1", pc_inc); end
    vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL rst_halted got %b want 0", halted); end
    vec_cnt++; if (fetch_req !== 1'b0) begin err_cnt++; $display("FAIL rst_fetch_req got %b want 0", fetch_req); end
    step();
    step();
  endtask

  // Startup window of 3 cycles, inputs ignored, then first fetch of 3C.
  task automatic test_rseq_fetch();
    reset = 1'b0;
    pcra_flip_in = 1'b1; bus_request_in = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      vec_cnt++; if (flag_reset !== 1'b1) begin err_cnt++; $display("FAIL rseq_flag_reset e%0d got %b want 1", i, flag_reset); end
      vec_cnt++; if (instruction !== 8'h00 || pc_inc !== 1'b1 || fetch_req !== 1'b0) begin
        err_cnt++; $display("FAIL rseq_outputs e%0d got instr=%h pc_inc=%b fetch_req=%b want 00/1/0", i, instruction, pc_inc, fetch_req);
      end
    end
    step();
    vec_cnt++; if (flag_reset !== 1'b0) begin err_cnt++; $display("FAIL rseq_end_flag_reset got %b want 0", flag_reset); end
    vec_cnt++; if (fetch_req !== 1'b1) begin err_cnt++; $display("FAIL rseq_end_fetch_req got %b want 1", fetch_req); end
    vec_cnt++; if (flag_pcraflip !== 1'b0) begin err_cnt++; $display("FAIL rseq_pcra_ignored got %b want 0", flag_pcraflip); end
    vec_cnt++; if (instruction !== 8'h00) begin err_cnt++; $display("FAIL rseq_end_instr got %h want 00", instruction); end
    pcra_flip_in = 1'b0; bus_request_in = 1'b0;
    step();
    vec_cnt++; if (instruction !== 8'h3C) begin err_cnt++; $display("FAIL fetch_3c_instr got %h want 3c", instruction); end
    vec_cnt++; if (pc_inc !== 1'b0) begin err_cnt++; $display("FAIL fetch_3c_pc_inc got %b want 0", pc_inc); end
  endtask

  task automatic test_no_ready();
    mem_ready = 1'b0; mem_data = 8'h77;
    for (int i = 0; i < 2; i++) begin
      step();
      vec_cnt++; if (instruction !== 8'h00) begin err_cnt++; $display("FAIL noready_instr c%0d got %h want 00", i, instruction); end
      vec_cnt++; if (pc_inc !== 1'b1) begin err_cnt++; $display("FAIL noready_pc_inc c%0d got %b want 1", i, pc_inc); end
      vec_cnt++; if (fetch_req !== 1'b1) begin err_cnt++; $display("FAIL noready_fetch_req c%0d got %b want 1", i, fetch_req); end
    end
  endtask

  task automatic test_bus_stall();
    mem_ready = 1'b1; mem_data = 8'hA5; bus_request_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++; if (instruction !== 8'h00) begin err_cnt++; $display("FAIL stall_instr c%0d got %h want 00", i, instruction); end
      vec_cnt++; if (pc_inc !== 1'b1) begin err_cnt++; $display("FAIL stall_pc_inc c%0d got %b want 1", i, pc_inc); end
      vec_cnt++; if (fetch_req !== 1'b0) begin err_cnt++; $display("FAIL stall_fetch_req c%0d got %b want 0", i, fetch_req); end
    end
    bus_request_in = 1'b0;
    step();
    vec_cnt++; if (fetch_req !== 1'b1 || instruction !== 8'h00 || pc_inc !== 1'b1) begin
      err_cnt++; $display("FAIL stall_exit got fetch_req=%b instr=%h pc_inc=%b want 1/00/1", fetch_req, instruction, pc_inc);
    end
    step();
    vec_cnt++; if (instruction !== 8'hA5) begin err_cnt++; $display("FAIL stall_refetch_instr got %h want a5", instruction); end
    vec_cnt++; if (pc_inc !== 1'b0) begin err_cnt++; $display("FAIL stall_refetch_pc_inc got %b want 0", pc_inc); end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_break_halt();
    mem_ready = 1'b1; mem_data = 8'h5A; break_in = 1'b1; bus_request_in = 1'b1;
    step();
    vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("FAIL brk_halted got %b want 1", halted); end
    vec_cnt++; if (instruction !== 8'h00 || pc_inc !== 1'b1 || fetch_req !== 1'b0) begin
      err_cnt++; $display("FAIL brk_outputs got instr=%h pc_inc=%b fetch_req=%b want 00/1/0", instruction, pc_inc, fetch_req);
    end
    break_in = 1'b0; bus_request_in = 1'b0;
    step();
    vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("FAIL halt_hold got %b want 1", halted); end
    break_in = 1'b1; resume = 1'b1;
    step();
    vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("FAIL halt_brk_and_resume got %b want 1", halted); end
    break_in = 1'b0;
    step();
    vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL resume_halted got %b want 0", halted); end
    vec_cnt++; if (fetch_req !== 1'b1) begin err_cnt++; $display("FAIL resume_fetch_req got %b want 1", fetch_req); end
    resume = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_pcra_reset();
    pcra_flip_in = 1'b1;
    step();
    vec_cnt++; if (flag_pcraflip !== 1'b1) begin err_cnt++; $display("FAIL pcra_fetch got %b want 1", flag_pcraflip); end
    pcra_flip_in = 1'b0; bus_request_in = 1'b1;
    step();
    vec_cnt++; if (flag_pcraflip !== 1'b1) begin err_cnt++; $display("FAIL pcra_hold got %b want 1", flag_pcraflip); end
    pcra_flip_in = 1'b1;
    step();
    vec_cnt++; if (flag_pcraflip !== 1'b0) begin err_cnt++; $display("FAIL pcra_stall got %b want 0", flag_pcraflip); end
    bus_request_in = 1'b0;
    step();
    vec_cnt++; if (flag_pcraflip !== 1'b1) begin err_cnt++; $display("FAIL pcra_third got %b want 1", flag_pcraflip); end
    pcra_flip_in = 1'b0; break_in = 1'b1;
    step();
    vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("FAIL pcra_halt_entry got %b want 1", halted); end
    break_in = 1'b0;
    #3 reset = 1'b1;
    #1;
    vec_cnt++; if (flag_pcraflip !== 1'b0) begin err_cnt++; $display("FAIL async_rst_pcra got %b want 0", flag_pcraflip); end
    vec_cnt++; if (flag_reset !== 1'b1) begin err_cnt++; $display("FAIL async_rst_flag_reset got %b want 1", flag_reset); end
    vec_cnt++; if (halted !== 1'b0 || fetch_req !== 1'b0) begin
      err_cnt++; $display("FAIL async_rst_state got halted=%b fetch_req=%b want 0/0", halted, fetch_req);
    end
    step();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      vec_cnt++; if (flag_reset !== (i < 3 ? 1'b1 : 1'b0)) begin
        err_cnt++; $display("FAIL rerun_flag_reset e%0d got %b want %b", i, flag_reset, (i < 3 ? 1'b1 : 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rseq_fetch();
    test_no_ready();
    test_bus_stall();
    test_break_halt();
    test_pcra_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
